// File: rtl/intram_pkg.sv
// Shared types and constants for the internal-RAM arbiter slice.
package intram_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} intram_state_t;

  typedef logic port_sel_t;

  localparam int RAM_DW   = 32;
  localparam int RAM_BE_W = 4;

endpackage

// File: rtl/intram_arbiter_rr_arbiter2.sv
// Two-input round-robin pick; the last-grant history register lives in the parent.
module rr_arbiter2
  import intram_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_sel_t  last_grant_i,
  output port_sel_t  grant_o,
  output logic       valid_o
);

  always_comb begin
    grant_o = 1'b0;
    case (req_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = ~last_grant_i;
      default: grant_o = 1'b0;
    endcase
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/intram_arbiter.sv
// Round-robin sharing of one single-port internal RAM between an instruction-fetch
// master (m0) and a data master (m1), both Wishbone classic.
//
// state  | meaning
// IDLE   | waiting for a request; winner's address/data captured on grant
// ACCESS | RAM address/controls presented, RAM samples on the closing edge
// RESP   | ack or err returned to the granted master if it still holds cyc
module intram_arbiter
  import intram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int BUS_AW = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,

  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [BUS_AW-1:0]   m0_adr_i,
  input  logic [RAM_BE_W-1:0] m0_sel_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  output logic [DATA_W-1:0]   m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,

  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [BUS_AW-1:0]   m1_adr_i,
  input  logic [RAM_BE_W-1:0] m1_sel_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  output logic [DATA_W-1:0]   m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,

  output logic                ram_we_o,
  output logic [ADDR_W-1:0]   ram_adr_o,
  output logic [RAM_BE_W-1:0] ram_be_o,
  output logic [DATA_W-1:0]   ram_dat_o,
  input  logic [DATA_W-1:0]   ram_dat_i
);

  intram_state_t         state_q, state_d;
  port_sel_t             last_grant_q, last_grant_d;
  port_sel_t             gnt_q, gnt_d;
  logic                  oob_q, oob_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     adr_q, adr_d;
  logic [RAM_BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0]     dat_q, dat_d;

  logic [1:0]            req;
  port_sel_t             arb_idx;
  logic                  arb_valid;

  logic                  sel_we;
  logic [BUS_AW-1:0]     sel_adr;
  logic [RAM_BE_W-1:0]   sel_be;
  logic [DATA_W-1:0]     sel_dat;
  logic                  gnt_cyc;

  // Byte-offset bits never reach the word-addressed RAM.
  logic                  unused_adr_lsb;
  assign unused_adr_lsb = &{1'b0, m0_adr_i[1:0], m1_adr_i[1:0]};

  assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  rr_arbiter2 u_rr (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_idx),
    .valid_o      (arb_valid)
  );

  assign sel_we  = arb_idx ? m1_we_i  : m0_we_i;
  assign sel_adr = arb_idx ? m1_adr_i : m0_adr_i;
  assign sel_be  = arb_idx ? m1_sel_i : m0_sel_i;
  assign sel_dat = arb_idx ? m1_dat_i : m0_dat_i;
  assign gnt_cyc = gnt_q ? m1_cyc_i : m0_cyc_i;

  assign ram_adr_o = adr_q;
  assign ram_be_o  = be_q;
  assign ram_dat_o = dat_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      oob_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      be_q         <= '0;
      dat_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      oob_q        <= oob_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      be_q         <= be_d;
      dat_q        <= dat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    oob_d        = oob_q;
    we_d         = we_q;
    adr_d        = adr_q;
    be_d         = be_q;
    dat_d        = dat_q;
    ram_we_o     = 1'b0;
    m0_ack_o     = 1'b0;
    m0_err_o     = 1'b0;
    m0_dat_o     = '0;
    m1_ack_o     = 1'b0;
    m1_err_o     = 1'b0;
    m1_dat_o     = '0;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d        = arb_idx;
          last_grant_d = arb_idx;
          we_d         = sel_we;
          adr_d        = sel_adr[ADDR_W+1:2];
          be_d         = sel_be;
          dat_d        = sel_dat;
          oob_d        = |sel_adr[BUS_AW-1:ADDR_W+2];
          state_d      = ACCESS;
        end
      end

      ACCESS: begin
        ram_we_o = we_q & ~oob_q;
        state_d  = RESP;
      end

      RESP: begin
        state_d = IDLE;
        // A master that dropped cyc has abandoned the cycle; stay silent toward it.
        if (gnt_cyc) begin
          if (gnt_q == 1'b0) begin
            m0_ack_o = ~oob_q;
            m0_err_o = oob_q;
            m0_dat_o = (we_q | oob_q) ? '0 : ram_dat_i;
          end else begin
            m1_ack_o = ~oob_q;
            m1_err_o = oob_q;
            m1_dat_o = (we_q | oob_q) ? '0 : ram_dat_i;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_intram_arbiter.sv
// Directed bench for intram_arbiter with a behavioural registered-read RAM.
module tb_intram_arbiter;
  import intram_pkg::*;

  logic        clk;
  logic        rst_n;

  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat_w;
  logic [3:0]  m0_sel;
  logic [31:0] m0_dat_r;
  logic        m0_ack, m0_err;

  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat_w;
  logic [3:0]  m1_sel;
  logic [31:0] m1_dat_r;
  logic        m1_ack, m1_err;

  logic        ram_we;
  logic [7:0]  ram_adr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdat;
  logic [31:0] ram_rdat;

  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  intram_arbiter #(.ADDR_W(8), .BUS_AW(32), .DATA_W(32)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .m0_cyc_i  (m0_cyc),
    .m0_stb_i  (m0_stb),
    .m0_we_i   (m0_we),
    .m0_adr_i  (m0_adr),
    .m0_sel_i  (m0_sel),
    .m0_dat_i  (m0_dat_w),
    .m0_dat_o  (m0_dat_r),
    .m0_ack_o  (m0_ack),
    .m0_err_o  (m0_err),
    .m1_cyc_i  (m1_cyc),
    .m1_stb_i  (m1_stb),
    .m1_we_i   (m1_we),
    .m1_adr_i  (m1_adr),
    .m1_sel_i  (m1_sel),
    .m1_dat_i  (m1_dat_w),
    .m1_dat_o  (m1_dat_r),
    .m1_ack_o  (m1_ack),
    .m1_err_o  (m1_err),
    .ram_we_o  (ram_we),
    .ram_adr_o (ram_adr),
    .ram_be_o  (ram_be),
    .ram_dat_o (ram_wdat),
    .ram_dat_i (ram_rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: byte-enable write, registered read returning pre-write data.
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_adr][8*b +: 8] <= ram_wdat[8*b +: 8];
    end
    ram_rdat <= mem[ram_adr];
  end

  task automatic idle_masters();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_sel = 0; m0_dat_w = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_sel = 0; m1_dat_w = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input bit p, input bit we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat);
    if (p == 1'b0) begin
      m0_cyc = 1; m0_stb = 1; m0_we = we; m0_adr = adr; m0_sel = sel; m0_dat_w = dat;
    end else begin
      m1_cyc = 1; m1_stb = 1; m1_we = we; m1_adr = adr; m1_sel = sel; m1_dat_w = dat;
    end
  endtask

  // Runs one access on port p; lat counts edges from request until ack/err (-1 on timeout).
  task automatic do_access(input bit p, input bit we, input logic [31:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat,
                           output bit ack, output bit err, output logic [31:0] rd,
                           output int lat, output int we_cnt,
                           output logic [7:0] adr_seen, output logic [3:0] be_seen);
    @(negedge clk);
    drive(p, we, adr, sel, dat);
    ack = 0; err = 0; rd = 0; lat = -1; we_cnt = 0; adr_seen = 0; be_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ram_we) we_cnt++;
      if (i == 1) begin
        adr_seen = ram_adr;
        be_seen  = ram_be;
      end
      if (p == 1'b0 && (m0_ack || m0_err)) begin
        ack = m0_ack; err = m0_err; rd = m0_dat_r; lat = i;
        break;
      end
      if (p == 1'b1 && (m1_ack || m1_err)) begin
        ack = m1_ack; err = m1_err; rd = m1_dat_r; lat = i;
        break;
      end
    end
    @(posedge clk);
    #1 idle_masters();
  endtask

  task automatic test_reset();
    idle_masters();
    apply_reset();
    #1;
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
    end
    checks++;
    if ({m0_ack, m0_err, m1_ack, m1_err, ram_we} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 00000",
                         {m0_ack, m0_err, m1_ack, m1_err, ram_we});
    end
    checks++;
    if ({ram_adr, ram_be, ram_wdat, m0_dat_r, m1_dat_r} !== '0) begin
      errors++; $display("FAIL reset_buses: adr %h be %h wdat %h d0 %h d1 %h expected all 0",
                         ram_adr, ram_be, ram_wdat, m0_dat_r, m1_dat_r);
    end
  endtask

  task automatic test_write_read();
    bit ack, err; logic [31:0] rd; int lat, wc; logic [7:0] a; logic [3:0] be;
    do_access(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, ack, err, rd, lat, wc, a, be);
    checks++;
    if (ack !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL wr_ack: ack %0b err %0b expected 1 0", ack, err);
    end
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL wr_latency: got %0d edges expected 2", lat);
    end
    checks++;
    if (wc !== 1) begin
      errors++; $display("FAIL wr_we_cycles: got %0d expected 1", wc);
    end
    checks++;
    if (a !== 8'h04 || be !== 4'hF) begin
      errors++; $display("FAIL wr_ram_addr_be: adr %h be %h expected 04 f", a, be);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL wr_dat_o: got %h expected 00000000", rd);
    end
    do_access(0, 0, 32'h10, 4'hF, 32'h0, ack, err, rd, lat, wc, a, be);
    checks++;
    if (ack !== 1'b1 || rd !== 32'hDEADBEEF || wc !== 0) begin
      errors++; $display("FAIL rd_back: ack %0b dat %h we %0d expected 1 deadbeef 0", ack, rd, wc);
    end
  endtask

  task automatic test_byte_write();
    bit ack, err; logic [31:0] rd; int lat, wc; logic [7:0] a; logic [3:0] be;
    do_access(1, 1, 32'h10, 4'b0010, 32'h0000AA00, ack, err, rd, lat, wc, a, be);
    checks++;
    if (ack !== 1'b1 || be !== 4'b0010) begin
      errors++; $display("FAIL byte_wr: ack %0b be %b expected 1 0010", ack, be);
    end
    do_access(1, 0, 32'h10, 4'hF, 32'h0, ack, err, rd, lat, wc, a, be);
    checks++;
    if (rd !== 32'hDEADAAEF) begin
      errors++; $display("FAIL byte_rd: got %h expected deadaaef", rd);
    end
    do_access(0, 1, 32'h10, 4'h0, 32'h55555555, ack, err, rd, lat, wc, a, be);
    checks++;
    if (ack !== 1'b1 || err !== 1'b0 || be !== 4'h0) begin
      errors++; $display("FAIL sel0_wr: ack %0b err %0b be %h expected 1 0 0", ack, err, be);
    end
    do_access(0, 0, 32'h10, 4'hF, 32'h0, ack, err, rd, lat, wc, a, be);
    checks++;
    if (rd !== 32'hDEADAAEF) begin
      errors++; $display("FAIL sel0_rd: got %h expected deadaaef", rd);
    end
  endtask

  task automatic test_round_robin();
    int order [8];
    int n;
    bit dual;
    idle_masters();
    apply_reset();
    drive(0, 0, 32'h10, 4'hF, 32'h0);
    drive(1, 0, 32'h10, 4'hF, 32'h0);
    n = 0;
    dual = 0;
    for (int i = 0; i < 40 && n < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if ((m0_ack || m0_err) && (m1_ack || m1_err)) dual = 1;
      if (m0_ack) begin order[n] = 0; n++; end
      else if (m1_ack) begin order[n] = 1; n++; end
    end
    @(posedge clk);
    #1 idle_masters();
    checks++;
    if (n !== 8) begin
      errors++; $display("FAIL rr_count: got %0d acks expected 8", n);
    end
    checks++;
    if (dual !== 1'b0) begin
      errors++; $display("FAIL rr_dual_ack: got %0b expected 0", dual);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (k < n && order[k] !== (k % 2)) begin
        errors++; $display("FAIL rr_order[%0d]: got m%0d expected m%0d", k, order[k], k % 2);
      end else if (k >= n) begin
        errors++; $display("FAIL rr_order[%0d]: got none expected m%0d", k, k % 2);
      end
    end
  endtask

  task automatic test_out_of_range();
    bit ack, err; logic [31:0] rd; int lat, wc; logic [7:0] a; logic [3:0] be;
    do_access(0, 1, 32'h0, 4'hF, 32'h11111111, ack, err, rd, lat, wc, a, be);
    do_access(1, 0, 32'h400, 4'hF, 32'h0, ack, err, rd, lat, wc, a, be);
    checks++;
    if (err !== 1'b1 || ack !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL oob_rd: err %0b ack %0b lat %0d expected 1 0 2", err, ack, lat);
    end
    checks++;
    if (wc !== 0 || rd !== 32'h0) begin
      errors++; $display("FAIL oob_rd_side: we %0d dat %h expected 0 00000000", wc, rd);
    end
    do_access(1, 1, 32'h400, 4'hF, 32'hFFFFFFFF, ack, err, rd, lat, wc, a, be);
    checks++;
    if (err !== 1'b1 || wc !== 0) begin
      errors++; $display("FAIL oob_wr: err %0b we %0d expected 1 0", err, wc);
    end
    do_access(0, 0, 32'h0, 4'hF, 32'h0, ack, err, rd, lat, wc, a, be);
    checks++;
    if (rd !== 32'h11111111) begin
      errors++; $display("FAIL oob_word0: got %h expected 11111111", rd);
    end
  endtask

  task automatic test_abort();
    bit stray, got1;
    logic [31:0] d1;
    @(negedge clk);
    drive(0, 1, 32'h20, 4'hF, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0;
    drive(1, 0, 32'h20, 4'hF, 32'h0);
    stray = 0; got1 = 0; d1 = 0;
    for (int i = 0; i < 12 && !got1; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (m0_ack || m0_err) stray = 1;
      if (m1_ack) begin got1 = 1; d1 = m1_dat_r; end
    end
    @(posedge clk);
    #1 idle_masters();
    checks++;
    if (stray !== 1'b0) begin
      errors++; $display("FAIL abort_no_resp: got m0 ack/err %0b expected 0", stray);
    end
    checks++;
    if (got1 !== 1'b1 || d1 !== 32'h12345678) begin
      errors++; $display("FAIL abort_m1_served: ack %0b dat %h expected 1 12345678", got1, d1);
    end
  endtask

  task automatic test_reset_mid_access();
    bit ack, err; logic [31:0] rd; int lat, wc; logic [7:0] a; logic [3:0] be;
    do_access(1, 1, 32'h30, 4'hF, 32'h0BADBEEF, ack, err, rd, lat, wc, a, be);
    @(negedge clk);
    drive(1, 1, 32'h30, 4'hF, 32'hCAFEF00D);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b1) begin
      errors++; $display("FAIL rst_pre_we: got %0b expected 1", ram_we);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_we, m0_ack, m0_err, m1_ack, m1_err} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got %b expected 00000",
                         {ram_we, m0_ack, m0_err, m1_ack, m1_err});
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++; $display("FAIL rst_mid_state: got %0d expected %0d", dut.state_q, IDLE);
    end
    idle_masters();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_access(0, 0, 32'h30, 4'hF, 32'h0, ack, err, rd, lat, wc, a, be);
    checks++;
    if (rd !== 32'h0BADBEEF) begin
      errors++; $display("FAIL rst_mid_mem: got %h expected 0badbeef", rd);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_masters();
    test_reset();
    test_write_read();
    test_byte_write();
    test_round_robin();
    test_out_of_range();
    test_abort();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
